pipe_fifo: RTL and testbench
============================

PIPE_FIFO -- requirements
Module: pipe_fifo

Interface
REQ-001 Parameter WIDTH, default 8, data beat width in bits; SHALL be >= 1.
REQ-002 Parameter DEPTH, default 4, number of storage entries; SHALL be a power of two, >= 2.
REQ-003 Parameter AFULL_THRESH, default 3, occupancy at or above which o_afull asserts; SHALL be in 1..DEPTH.
REQ-004 clk  input  1  clock; all state SHALL change only on its rising edge.
REQ-005 i_reset_n  input  1  reset, synchronous, active-low.
REQ-006 i_flush  input  1  synchronous discard of all stored beats.
REQ-007 i_data  input  WIDTH  upstream data beat.
REQ-008 i_vld  input  1  upstream beat valid.
REQ-009 o_rdy  output  1  space available, upstream may transfer.
REQ-010 o_data  output  WIDTH  head-of-queue data beat.
REQ-011 o_vld  output  1  head-of-queue beat valid.
REQ-012 i_rdy  input  1  downstream accepts beat.
REQ-013 o_count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-014 o_afull  output  1  occupancy >= AFULL_THRESH.

Function
REQ-015 Write beat SHALL occur on an edge where i_vld && o_rdy; read beat SHALL occur on an edge where o_vld && i_rdy.
REQ-016 Beats SHALL leave in exactly the order they entered; no beat is duplicated or lost, except by flush or reset.
REQ-017 o_rdy SHALL equal (o_count < DEPTH), with no combinational path from i_vld, i_rdy, i_data or i_flush.
REQ-018 o_vld SHALL equal (o_count != 0), with no combinational path from any input.
REQ-019 o_data SHALL present the oldest stored beat when o_vld=1 and SHALL be all-zero when o_vld=0.
REQ-020 Latency: a beat written at edge N SHALL be visible on o_vld/o_data after edge N if the FIFO was empty; there is no same-cycle pass-through.
REQ-021 Simultaneous read and write SHALL leave o_count unchanged and advance both pointers, including at count=DEPTH-1 and count=1.
REQ-022 When full (count=DEPTH), o_rdy=0 and a read in that cycle SHALL NOT admit a write in the same cycle.
REQ-023 Read and write pointers SHALL be log2(DEPTH) bits and wrap from DEPTH-1 to 0 silently.
REQ-024 o_count SHALL increment on write-only, decrement on write-less read, and never exceed DEPTH nor drop below 0.
REQ-025 o_afull SHALL be registered-derived: (o_count >= AFULL_THRESH), combinational from o_count only.
REQ-026 i_flush=1 at an edge SHALL set count and both pointers to 0; any write or read in that cycle SHALL be discarded (no beat counted as transferred).
REQ-027 Storage contents SHALL NOT require reset; masking per REQ-019 hides stale data.

Reset
REQ-028 i_reset_n=0 at an edge SHALL set o_count=0, pointers=0, hence o_vld=0, o_rdy=1, o_afull=0 (if AFULL_THRESH>=1), o_data=0.
REQ-029 Reset SHALL take priority over i_flush and over any in-flight read or write, including mid-burst.
REQ-030 Outputs SHALL hold reset values from the first edge with i_reset_n=0 until the first edge with i_reset_n=1.

Structure
REQ-031 No shared package types are required; all widths SHALL derive locally from WIDTH and DEPTH.
REQ-032 Storage SHALL be a sub-module pipe_fifo_ram: DEPTH x WIDTH, one synchronous write port, one asynchronous read port, no reset.
REQ-033 Pointer, count and handshake logic SHALL reside in pipe_fifo itself.

Verification
REQ-034 Reset, then write 0x11,0x22,0x33,0x44 with i_rdy=0 -> o_count 1,2,3,4; o_afull rises after third write; o_rdy=0 after fourth.
REQ-035 From full, i_rdy=1 and i_vld=1 for 4 cycles -> o_data 0x11..0x44 in order; writes accepted only once count<4; no loss.
REQ-036 Steady stream, i_vld=i_rdy=1 for 20 cycles at count=1 -> o_count stays 1, pointers wrap 5 times, output sequence equals input delayed one beat.
REQ-037 Count=3, assert i_flush with i_vld=1 and i_rdy=1 -> next cycle o_count=0, o_vld=0, o_data=0, o_rdy=1; flushed-cycle beat absent from later output.
REQ-038 Assert i_reset_n=0 mid-burst at count=2 -> next cycle reset values per REQ-028; first beat after release emerges alone.
REQ-039 Random i_vld/i_rdy, 10k cycles, DEPTH=8, WIDTH=16 -> scoreboard ordering match; o_count equals writes minus reads each cycle.

Source files
------------

// File: rtl/pipe_fifo_pkg.sv
// Shared definitions for the pipelined FIFO: classification of each cycle's transfers.
package pipe_fifo_pkg;

  // What happens to the queue on a given edge, encoded as {read, write}
  typedef enum logic [1:0] {
    OP_IDLE  = 2'b00,
    OP_WRITE = 2'b01,
    OP_READ  = 2'b10,
    OP_BOTH  = 2'b11
  } fifoOp_e;

  function automatic fifoOp_e classifyOp(input logic wrEn, input logic rdEn);
    return fifoOp_e'({rdEn, wrEn});
  endfunction

endpackage

// File: rtl/pipe_fifo_ram.sv
// DEPTH x WIDTH storage: one synchronous write port, one asynchronous read port, no reset.
module pipe_fifo_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [WIDTH-1:0]         rdata_o
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Capture the incoming beat at the write pointer; stale entries are masked downstream
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/pipe_fifo.sv
// Valid/ready FIFO: pointer, occupancy and handshake control around a small RAM.
// All status outputs come from registered occupancy, so no input reaches an output combinationally.
module pipe_fifo
  import pipe_fifo_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int DEPTH        = 4,
  parameter int AFULL_THRESH = 3
) (
  input  logic                   clk,
  input  logic                   i_reset_n,
  input  logic                   i_flush,
  input  logic [WIDTH-1:0]       i_data,
  input  logic                   i_vld,
  output logic                   o_rdy,
  output logic [WIDTH-1:0]       o_data,
  output logic                   o_vld,
  input  logic                   i_rdy,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_afull
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]    wrPtr_q, wrPtr_d;
  logic [AW-1:0]    rdPtr_q, rdPtr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             wrEn, rdEn, ramWe;
  logic [WIDTH-1:0] ramRdata;
  fifoOp_e          op;

  assign o_rdy = (count_q < CW'(DEPTH));
  assign o_vld = (count_q != '0);
  assign wrEn  = i_vld && o_rdy;
  assign rdEn  = o_vld && i_rdy;
  assign op    = classifyOp(wrEn, rdEn);
  assign ramWe = wrEn && i_reset_n && !i_flush;

  // Next pointers and occupancy; pointers wrap naturally at DEPTH since it is a power of two
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    case (op)
      OP_WRITE: begin
        wrPtr_d = wrPtr_q + AW'(1);
        count_d = count_q + CW'(1);
      end
      OP_READ: begin
        rdPtr_d = rdPtr_q + AW'(1);
        count_d = count_q - CW'(1);
      end
      OP_BOTH: begin
        wrPtr_d = wrPtr_q + AW'(1);
        rdPtr_d = rdPtr_q + AW'(1);
      end
      default: ;
    endcase
  end

  // Reset beats flush, and flush discards whatever transfer was attempted in the same cycle
  always_ff @(posedge clk) begin
    if (!i_reset_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else if (i_flush) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  pipe_fifo_ram #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_ram (
    .clk    (clk),
    .we_i   (ramWe),
    .waddr_i(wrPtr_q),
    .wdata_i(i_data),
    .raddr_i(rdPtr_q),
    .rdata_o(ramRdata)
  );

  assign o_data  = o_vld ? ramRdata : '0;
  assign o_count = count_q;
  assign o_afull = (count_q >= CW'(AFULL_THRESH));

endmodule

// File: tb/tb_pipe_fifo.sv
// Bench for pipe_fifo: a hand-derived vector table on a default-size instance,
// plus queue scoreboards for a steady stream and a long random run on a wider, deeper instance.
module tb_pipe_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst4_n, flush4, vld4, rdy4;
  logic [7:0] data4, odata4;
  logic       ordy4, ovld4, oafull4;
  logic [2:0] ocount4;

  logic        rst8_n, flush8, vld8, rdy8;
  logic [15:0] data8, odata8;
  logic        ordy8, ovld8, oafull8;
  logic [3:0]  ocount8;

  pipe_fifo dut4 (
    .clk      (clk),
    .i_reset_n(rst4_n),
    .i_flush  (flush4),
    .i_data   (data4),
    .i_vld    (vld4),
    .o_rdy    (ordy4),
    .o_data   (odata4),
    .o_vld    (ovld4),
    .i_rdy    (rdy4),
    .o_count  (ocount4),
    .o_afull  (oafull4)
  );

  pipe_fifo #(
    .WIDTH(16),
    .DEPTH(8),
    .AFULL_THRESH(6)
  ) dut8 (
    .clk      (clk),
    .i_reset_n(rst8_n),
    .i_flush  (flush8),
    .i_data   (data8),
    .i_vld    (vld8),
    .o_rdy    (ordy8),
    .o_data   (odata8),
    .o_vld    (ovld8),
    .i_rdy    (rdy8),
    .o_count  (ocount8),
    .o_afull  (oafull8)
  );

  typedef struct {
    logic       rstN;
    logic       flush;
    logic       vld;
    logic       rdy;
    logic [7:0] data;
    logic [2:0] expCount;
    logic       expVld;
    logic       expRdy;
    logic       expAfull;
    logic [7:0] expData;
  } vec_t;

  localparam int NVEC = 26;
  vec_t vecs [NVEC];

  int checks   = 0;
  int failures = 0;

  logic [7:0]  q4 [$];
  logic [15:0] q8 [$];
  int          m4 = 0;
  int          m8 = 0;

  function automatic vec_t mk(input logic r, input logic f, input logic v, input logic y,
                              input logic [7:0] d, input logic [2:0] c, input logic ev,
                              input logic er, input logic ea, input logic [7:0] ed);
    vec_t t;
    t.rstN = r; t.flush = f; t.vld = v; t.rdy = y; t.data = d;
    t.expCount = c; t.expVld = ev; t.expRdy = er; t.expAfull = ea; t.expData = ed;
    return t;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input vec_t v);
    rst4_n = v.rstN;
    flush4 = v.flush;
    vld4   = v.vld;
    rdy4   = v.rdy;
    data4  = v.data;
    tick();
  endtask

  // One cycle on the default instance with the queue model predicting every transfer
  task automatic sbStep4(input logic vld, input logic rdy, input logic [7:0] d);
    logic [7:0] expHead;
    rst4_n = 1'b1;
    flush4 = 1'b0;
    vld4   = vld;
    rdy4   = rdy;
    data4  = d;
    if (rdy && m4 != 0) begin
      expHead = q4.pop_front();
      checkOutput("stream data", 32'(odata4), 32'(expHead));
      m4--;
    end
    if (vld && (m4 < 4 || (rdy && m4 == 3 && q4.size() == 3 && 0))) begin
      q4.push_back(d);
      m4++;
    end
    tick();
    checkOutput("stream count", 32'(ocount4), 32'(m4));
  endtask

  initial begin
    vecs[0]  = mk(0,0,0,0,8'h00, 0,0,1,0,8'h00);
    vecs[1]  = mk(0,0,1,1,8'h99, 0,0,1,0,8'h00);
    vecs[2]  = mk(1,0,1,0,8'h11, 1,1,1,0,8'h11);
    vecs[3]  = mk(1,0,1,0,8'h22, 2,1,1,0,8'h11);
    vecs[4]  = mk(1,0,1,0,8'h33, 3,1,1,1,8'h11);
    vecs[5]  = mk(1,0,1,0,8'h44, 4,1,0,1,8'h11);
    vecs[6]  = mk(1,0,1,0,8'h55, 4,1,0,1,8'h11);
    vecs[7]  = mk(1,0,1,1,8'h55, 3,1,1,1,8'h22);
    vecs[8]  = mk(1,0,1,1,8'h66, 3,1,1,1,8'h33);
    vecs[9]  = mk(1,0,1,1,8'h77, 3,1,1,1,8'h44);
    vecs[10] = mk(1,0,1,1,8'h88, 3,1,1,1,8'h66);
    vecs[11] = mk(1,0,0,1,8'h00, 2,1,1,0,8'h77);
    vecs[12] = mk(1,0,0,1,8'h00, 1,1,1,0,8'h88);
    vecs[13] = mk(1,0,0,1,8'h00, 0,0,1,0,8'h00);
    vecs[14] = mk(1,0,1,0,8'hA1, 1,1,1,0,8'hA1);
    vecs[15] = mk(1,0,1,0,8'hA2, 2,1,1,0,8'hA1);
    vecs[16] = mk(1,0,1,0,8'hA3, 3,1,1,1,8'hA1);
    vecs[17] = mk(1,1,1,1,8'hA4, 0,0,1,0,8'h00);
    vecs[18] = mk(1,0,1,0,8'hB1, 1,1,1,0,8'hB1);
    vecs[19] = mk(1,0,0,1,8'h00, 0,0,1,0,8'h00);
    vecs[20] = mk(1,0,1,0,8'hC1, 1,1,1,0,8'hC1);
    vecs[21] = mk(1,0,1,0,8'hC2, 2,1,1,0,8'hC1);
    vecs[22] = mk(0,1,1,1,8'hC3, 0,0,1,0,8'h00);
    vecs[23] = mk(0,0,1,1,8'hC4, 0,0,1,0,8'h00);
    vecs[24] = mk(1,0,1,0,8'hD1, 1,1,1,0,8'hD1);
    vecs[25] = mk(1,0,0,1,8'h00, 0,0,1,0,8'h00);

    rst4_n = 1'b0; flush4 = 1'b0; vld4 = 1'b0; rdy4 = 1'b0; data4 = '0;
    rst8_n = 1'b0; flush8 = 1'b0; vld8 = 1'b0; rdy8 = 1'b0; data8 = '0;
    tick();
    tick();

    // Table-driven directed sequence on the 4-deep instance
    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d count", i), 32'(ocount4), 32'(vecs[i].expCount));
      checkOutput($sformatf("vec%0d vld", i),   32'(ovld4),   32'(vecs[i].expVld));
      checkOutput($sformatf("vec%0d rdy", i),   32'(ordy4),   32'(vecs[i].expRdy));
      checkOutput($sformatf("vec%0d afull", i), 32'(oafull4), 32'(vecs[i].expAfull));
      checkOutput($sformatf("vec%0d data", i),  32'(odata4),  32'(vecs[i].expData));
    end

    // Steady stream at occupancy 1: output equals input delayed by one beat
    sbStep4(1'b1, 1'b0, 8'h40);
    for (int i = 0; i < 20; i++) begin
      sbStep4(1'b1, 1'b1, 8'(8'h41 + i));
    end
    sbStep4(1'b0, 1'b1, 8'h00);
    sbStep4(1'b0, 1'b1, 8'h00);
    checkOutput("stream drained data", 32'(odata4), 32'h0);
    checkOutput("stream drained vld", 32'(ovld4), 32'h0);

    // Reset state of the 8-deep instance, then a long random run against the queue model
    checkOutput("d8 reset count", 32'(ocount8), 32'h0);
    checkOutput("d8 reset rdy", 32'(ordy8), 32'h1);
    checkOutput("d8 reset vld", 32'(ovld8), 32'h0);
    checkOutput("d8 reset data", 32'(odata8), 32'h0);
    checkOutput("d8 reset afull", 32'(oafull8), 32'h0);
    rst8_n = 1'b1;
    for (int c = 0; c < 10000; c++) begin
      logic v, r;
      logic [15:0] d;
      logic [15:0] expHead;
      if (c < 5000) begin
        v = ($urandom_range(0, 99) < 70);
        r = ($urandom_range(0, 99) < 40);
      end else begin
        v = ($urandom_range(0, 99) < 40);
        r = ($urandom_range(0, 99) < 70);
      end
      d = 16'($urandom);
      vld8 = v; rdy8 = r; data8 = d;
      if (m8 == 0) begin
        checkOutput("rand empty data", 32'(odata8), 32'h0);
      end
      if (r && m8 != 0) begin
        expHead = q8.pop_front();
        checkOutput("rand data", 32'(odata8), 32'(expHead));
        if (v && m8 < 8) begin
          q8.push_back(d);
        end else begin
          m8--;
        end
      end else if (v && m8 < 8) begin
        q8.push_back(d);
        m8++;
      end
      tick();
      checkOutput("rand count", 32'(ocount8), 32'(m8));
      checkOutput("rand vld", 32'(ovld8), 32'(m8 != 0));
      checkOutput("rand rdy", 32'(ordy8), 32'(m8 < 8));
      checkOutput("rand afull", 32'(oafull8), 32'(m8 >= 6));
    end
    vld8 = 1'b0; rdy8 = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
